cpm_rst_seq: RTL

CPM_RST_SEQ -- requirements
Module: cpm_rst_seq

---
 rtl/cpm_rst_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cpm_rst_seq.sv
// CPM reset sequencer: POR hold, CDO load window, staggered per-channel PERST
// release, link-up supervision with bounded retry and a sticky error state.
module cpm_rst_seq #(
  parameter int NUM_CH         = 4,
  parameter int POR_DLY        = 500,
  parameter int PERST_DLY      = 12300,
  parameter int STAGGER_DLY    = 16,
  parameter int LINKUP_TIMEOUT = 65535,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] link_up,
  output logic              por_n,
  output logic [NUM_CH-1:0] perst_n,
  output logic [NUM_CH-1:0] user_reset,
  output logic              seq_done,
  output logic              seq_err,
  output logic [2:0]        state,
  output logic [1:0]        retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POR_HOLD  = 3'd1,
    S_CDO_WAIT  = 3'd2,
    S_PERST_REL = 3'd3,
    S_LINK_WAIT = 3'd4,
    S_RUN       = 3'd5,
    S_RETRY     = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [1:0]        retry_cnt_q, retry_cnt_d;
  logic              por_n_q, por_n_d;
  logic [NUM_CH-1:0] perst_n_q, perst_n_d;
  logic [NUM_CH-1:0] user_reset_q, user_reset_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_err_q, seq_err_d;

  logic              all_up;
  logic [31:0]       cnt_ext;
  logic [31:0]       cnt_d_ext;
  logic [31:0]       last_ofs;
  logic [31:0]       acc_ofs;
  logic [31:0]       rel_ofs;
  state_t            fail_state;
  logic [1:0]        fail_rc;

  always_comb begin
    cnt_ext  = 32'(cnt_q);
    // Disabled channels count as up so only the enabled mask gates RUN.
    all_up   = &(link_up | ~en_q);

    // Release offset of the highest enabled channel; PERST_REL ends after it.
    acc_ofs  = '0;
    last_ofs = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q[i]) begin
        last_ofs = acc_ofs;
        acc_ofs  = acc_ofs + 32'(STAGGER_DLY);
      end
    end

    if (32'(retry_cnt_q) < 32'(MAX_RETRY)) begin
      fail_state = S_RETRY;
      fail_rc    = (&retry_cnt_q) ? retry_cnt_q : retry_cnt_q + 2'd1;
    end else begin
      fail_state = S_ERR;
      fail_rc    = retry_cnt_q;
    end

    state_d     = state_q;
    en_d        = en_q;
    retry_cnt_d = retry_cnt_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start && (|ch_en)) begin
            state_d     = S_POR_HOLD;
            en_d        = ch_en;
            retry_cnt_d = 2'd0;
          end
        end
        S_POR_HOLD:  if (cnt_ext == 32'(POR_DLY - 1))   state_d = S_CDO_WAIT;
        S_CDO_WAIT:  if (cnt_ext == 32'(PERST_DLY - 1)) state_d = S_PERST_REL;
        S_RETRY:     if (cnt_ext == 32'(PERST_DLY - 1)) state_d = S_PERST_REL;
        S_PERST_REL: if (cnt_ext == last_ofs)           state_d = S_LINK_WAIT;
        S_LINK_WAIT: begin
          // Link-up wins over a timeout landing in the same cycle.
          if (all_up) begin
            state_d = S_RUN;
          end else if (cnt_ext == 32'(LINKUP_TIMEOUT - 1)) begin
            state_d     = fail_state;
            retry_cnt_d = fail_rc;
          end
        end
        S_RUN: begin
          if (!all_up) begin
            state_d     = fail_state;
            retry_cnt_d = fail_rc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_RUN && state_q != S_RUN) retry_cnt_d = 2'd0;
    if (state_d == S_IDLE) begin
      en_d        = '0;
      retry_cnt_d = 2'd0;
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (&cnt_q)         cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
    cnt_d_ext = 32'(cnt_d);

    // Outputs are decoded from the next state so they change on the entry edge.
    por_n_d   = !(state_d == S_IDLE || state_d == S_POR_HOLD);
    perst_n_d = '0;
    rel_ofs   = '0;
    if (state_d == S_PERST_REL) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_d[i]) begin
          perst_n_d[i] = (cnt_d_ext >= rel_ofs);
          rel_ofs      = rel_ofs + 32'(STAGGER_DLY);
        end
      end
    end else if (state_d == S_LINK_WAIT || state_d == S_RUN) begin
      perst_n_d = en_d;
    end
    user_reset_d = ~(perst_n_q & perst_n_d);
    seq_done_d   = (state_d == S_RUN);
    seq_err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      en_q         <= '0;
      retry_cnt_q  <= 2'd0;
      por_n_q      <= 1'b0;
      perst_n_q    <= '0;
      user_reset_q <= '1;
      seq_done_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      retry_cnt_q  <= retry_cnt_d;
      por_n_q      <= por_n_d;
      perst_n_q    <= perst_n_d;
      user_reset_q <= user_reset_d;
      seq_done_q   <= seq_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign por_n      = por_n_q;
  assign perst_n    = perst_n_q;
  assign user_reset = user_reset_q;
  assign seq_done   = seq_done_q;
  assign seq_err    = seq_err_q;
  assign state      = state_q;
  assign retry_cnt  = retry_cnt_q;

endmodule
